reg_file_mp: RTL

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp_if.sv | 29 ++
 rtl/reg_file_mp.sv | 121 ++++++++++++
 2 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write port, packed multi-port read, and clear control.
// The master side drives requests and addresses. The slave side (the register file)
// drives the status outputs and the read data.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ready;
  logic                     wr_drop;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     clr_req;
  logic                     busy;
  logic                     clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, clr_req,
    input  wr_ready, wr_drop, rd_data, busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, clr_req,
    output wr_ready, wr_drop, rd_data, busy, clr_done
  );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with one write port, NUM_RD combinational read ports,
// and a sequencer that clears the whole file one entry per cycle.
// Entry 0 is hardwired to read zero.
// Optional macro REG_FILE_MP_BYPASS_EN: a read port that addresses the entry being
// written in the same cycle returns the incoming write data instead of the old value.
//
// state | meaning
// IDLE  | normal operation, writes accepted, clr_req starts a clear
// CLEAR | zeroing entry idx this cycle, writes rejected
// DONE  | single-cycle completion pulse, writes rejected
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              clr_we;
  logic              busy;
  logic              wr_accept;
  logic              wr_drop_q;
  logic [DATA_W-1:0] mem [DEPTH];

  assign busy          = (state_q != S_IDLE);
  assign bus.busy      = busy;
  assign bus.clr_done  = (state_q == S_DONE);
  assign bus.wr_ready  = ~busy;
  assign bus.wr_drop   = wr_drop_q;

  // Address 0 is not backed by storage writes, so it is silently discarded rather than dropped.
  assign wr_accept = bus.wr_en & ~busy & (bus.wr_addr != '0);

  // Sequencer state and clear-index registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. The clear starts at 1 because entry 0 never holds data.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          idx_d   = ADDR_W'(1);
        end
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        idx_d  = idx_q + ADDR_W'(1);
        if (idx_q == '1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A rejected write is reported one cycle later as a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= bus.wr_en & busy;
    end
  end

  // Storage. Host writes and sequencer clears never overlap, because writes need IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_we) begin
      mem[idx_q] <= '0;
    end else if (wr_accept) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Independent combinational read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] stored;
    assign ra     = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign stored = (ra == '0) ? '0 : mem[ra];
`ifdef REG_FILE_MP_BYPASS_EN
    assign bus.rd_data[k*DATA_W +: DATA_W] =
      (wr_accept && (bus.wr_addr == ra)) ? bus.wr_data : stored;
`else
    assign bus.rd_data[k*DATA_W +: DATA_W] = stored;
`endif
  end

endmodule
